data_mem: RTL

Data-memory responder for the single-cycle MIPS datapath. It sits on the load/store side of the CPU and serves the `mem_read`/`mem_write` requests the control unit raises. It answers each request with a one-cycle `ready` strobe after a programmable number of wait states, so the CPU can stall on slow memory. Storage is word-addressed, 32 bits wide, with per-byte write enables for `sb`/`sh`/`sw`.

---
 rtl/data_mem.sv | 91 +++++++++
 1 files changed

// File: rtl/data_mem.sv
// Wait-stated data memory for the MIPS load/store path: word-addressed 32-bit
// storage with byte-lane writes, answering each request with a one-cycle ready.
module data_mem #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       w_data,
  input  logic [3:0]        byte_en,
  output logic [31:0]       r_data,
  output logic              ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int          DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              write_q;
  logic [31:0]       mem [DEPTH];
  logic              commit;

  // The edge leaving WAIT with an exhausted counter is the one that enters RESP.
  // A clr forces state to IDLE asynchronously, so an interrupted write never commits.
  assign commit = (state == WAIT) && (cnt == 4'd0);

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      r_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            state   <= WAIT;
            cnt     <= WAIT_INIT;
            addr_q  <= address;
            wdata_q <= w_data;
            be_q    <= byte_en;
            write_q <= mem_write;  // write wins when both requests are high
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            if (!write_q) r_data <= mem[addr_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array deliberately has no reset; clearing it would turn a
  // RAM macro into thousands of resettable flops, and contents are undefined anyway.
  always_ff @(posedge clk) begin
    if (commit && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

endmodule
